// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Walks every input row of a combinational DUT, holds each row HOLD
//            cycles, samples and compares against a packed expected table.
//            Optional macro SWEEP_MISR_EN adds a 16-bit MISR signature port.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int HOLD  = 1,
    parameter logic [(1 << N_IN)*N_OUT-1:0] EXPECTED = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             step_valid,
    output logic [N_IN:0]    err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  fail_idx,
    output logic [N_OUT-1:0] fail_y
`ifdef SWEEP_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    localparam int c_HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD - 1);
    localparam logic [N_IN-1:0]     c_LAST_ROW  = '1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DRIVE  = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [N_IN-1:0]     r_stim;
    logic                r_done;
    logic                r_pass;
    logic [N_IN:0]       r_err_count;
    logic                r_fail_valid;
    logic [N_IN-1:0]     r_fail_idx;
    logic [N_OUT-1:0]    r_fail_y;

    logic [N_OUT-1:0]    w_exp_row;
    logic                w_mismatch;
    logic                w_start_accept;
    logic [N_IN:0]       w_err_next;

    assign w_exp_row      = EXPECTED[r_stim*N_OUT +: N_OUT];
    assign w_mismatch     = (r_state == c_ST_SAMPLE) && (dut_y != w_exp_row);
    assign w_start_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_err_next     = r_err_count + {{N_IN{1'b0}}, w_mismatch};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_hold_cnt   <= '0;
            r_stim       <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_y     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state      <= c_ST_DRIVE;
                        r_hold_cnt   <= '0;
                        r_stim       <= '0;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_idx   <= '0;
                        r_fail_y     <= '0;
                    end
                end
                c_ST_DRIVE: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state <= c_ST_SAMPLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                c_ST_SAMPLE: begin
                    r_err_count <= w_err_next;
                    // Only the first failing row of a sweep is kept.
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_idx   <= r_stim;
                        r_fail_y     <= dut_y;
                    end
                    if (r_stim == c_LAST_ROW) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state    <= c_ST_DRIVE;
                        r_stim     <= r_stim + N_IN'(1);
                        r_hold_cnt <= '0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef SWEEP_MISR_EN
    logic [15:0] r_misr;
    logic        w_misr_fb;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1.
    assign w_misr_fb = r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misr <= 16'h0000;
        end else if (w_start_accept) begin
            r_misr <= 16'h0000;
        end else if (r_state == c_ST_SAMPLE) begin
            r_misr <= {r_misr[14:0], w_misr_fb} ^ 16'(dut_y);
        end
    end

    assign signature = r_misr;
`endif

    assign stim       = r_stim;
    assign busy       = (r_state == c_ST_DRIVE) || (r_state == c_ST_SAMPLE);
    assign step_valid = (r_state == c_ST_SAMPLE);
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;
    assign fail_y     = r_fail_y;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Purpose  : Scoreboard bench for truth_table_sweeper (two configurations),
//            with optional SWEEP_MISR_EN signature checking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    typedef struct {
        int row;
        int cyc;
    } step_t;

    typedef struct {
        int          err;
        int          pass;
        int          fv;
        int          fidx;
        int          fy;
        int          dcyc;
        logic [15:0] sig;
    } sum_t;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [2:0] stim_a, fidx_a;
    logic [0:0] y_a, fy_a;
    logic [3:0] err_a;
    logic       busy_a, done_a, pass_a, step_a, fv_a;
    logic [1:0] stim_b, fidx_b, y_b, fy_b;
    logic [2:0] err_b;
    logic       busy_b, done_b, pass_b, step_b, fv_b;
`ifdef SWEEP_MISR_EN
    logic [15:0] sig_a, sig_b;
`endif

    logic       tab_a [8];
    logic [1:0] tab_b [4];
    assign y_a = tab_a[stim_a];
    assign y_b = tab_b[stim_b];

    step_t qsa[$], qsb[$];
    sum_t  qda[$], qdb[$];
    step_t sa, sb;
    sum_t  da, db;
    logic  prev_done_a = 1'b0;
    logic  prev_done_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .HOLD(1), .EXPECTED(8'b1110_1000)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stim(stim_a), .dut_y(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .step_valid(step_a),
        .err_count(err_a), .fail_valid(fv_a), .fail_idx(fidx_a), .fail_y(fy_a)
`ifdef SWEEP_MISR_EN
        , .signature(sig_a)
`endif
    );

    truth_table_sweeper #(.N_IN(2), .N_OUT(2), .HOLD(3), .EXPECTED(8'b11_10_01_00)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stim(stim_b), .dut_y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .step_valid(step_b),
        .err_count(err_b), .fail_valid(fv_b), .fail_idx(fidx_b), .fail_y(fy_b)
`ifdef SWEEP_MISR_EN
        , .signature(sig_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference functions: majority of three for A, identity for B.
    function automatic int exp_row_a(input int i);
        return ((((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1)) >= 2) ? 1 : 0;
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input int y);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb} ^ 16'(y);
    endfunction

    task automatic push_a(input int e);
        sum_t        s;
        logic [15:0] sig;
        s.err = 0; s.fv = 0; s.fidx = 0; s.fy = 0; sig = 16'h0000;
        for (int r = 0; r < 8; r++) begin
            qsa.push_back('{row: r, cyc: e + (r + 1) * 2 - 1});
            if (int'(tab_a[r]) != exp_row_a(r)) begin
                s.err++;
                if (s.fv == 0) begin s.fv = 1; s.fidx = r; s.fy = int'(tab_a[r]); end
            end
            sig = misr_step(sig, int'(tab_a[r]));
        end
        s.pass = (s.err == 0) ? 1 : 0;
        s.dcyc = e + 16;
        s.sig  = sig;
        qda.push_back(s);
    endtask

    task automatic push_b(input int e);
        sum_t        s;
        logic [15:0] sig;
        s.err = 0; s.fv = 0; s.fidx = 0; s.fy = 0; sig = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            qsb.push_back('{row: r, cyc: e + (r + 1) * 4 - 1});
            if (int'(tab_b[r]) != r) begin
                s.err++;
                if (s.fv == 0) begin s.fv = 1; s.fidx = r; s.fy = int'(tab_b[r]); end
            end
            sig = misr_step(sig, int'(tab_b[r]));
        end
        s.pass = (s.err == 0) ? 1 : 0;
        s.dcyc = e + 16;
        s.sig  = sig;
        qdb.push_back(s);
    endtask

    always @(negedge clk) begin
        if (step_a) begin
            if (qsa.size() == 0) chk("a_step_unexpected", 1, 0);
            else begin
                sa = qsa.pop_front();
                chk("a_step_stim", stim_a, sa.row);
                chk("a_step_cycle", cyc, sa.cyc);
                chk("a_step_busy", busy_a, 1);
                chk("a_pass_low", pass_a, 0);
            end
        end
        if (done_a && !prev_done_a) begin
            if (qda.size() == 0) chk("a_done_unexpected", 1, 0);
            else begin
                da = qda.pop_front();
                chk("a_done_cycle", cyc, da.dcyc);
                chk("a_err_count", err_a, da.err);
                chk("a_pass", pass_a, da.pass);
                chk("a_fail_valid", fv_a, da.fv);
                chk("a_fail_idx", fidx_a, da.fidx);
                chk("a_fail_y", fy_a, da.fy);
                chk("a_busy_in_done", busy_a, 0);
`ifdef SWEEP_MISR_EN
                chk("a_signature", sig_a, da.sig);
`endif
            end
        end
        prev_done_a <= done_a;
    end

    always @(negedge clk) begin
        if (step_b) begin
            if (qsb.size() == 0) chk("b_step_unexpected", 1, 0);
            else begin
                sb = qsb.pop_front();
                chk("b_step_stim", stim_b, sb.row);
                chk("b_step_cycle", cyc, sb.cyc);
                chk("b_pass_low", pass_b, 0);
            end
        end
        if (done_b && !prev_done_b) begin
            if (qdb.size() == 0) chk("b_done_unexpected", 1, 0);
            else begin
                db = qdb.pop_front();
                chk("b_done_cycle", cyc, db.dcyc);
                chk("b_err_count", err_b, db.err);
                chk("b_pass", pass_b, db.pass);
                chk("b_fail_valid", fv_b, db.fv);
                chk("b_fail_idx", fidx_b, db.fidx);
                chk("b_fail_y", fy_b, db.fy);
`ifdef SWEEP_MISR_EN
                chk("b_signature", sig_b, db.sig);
`endif
            end
        end
        prev_done_b <= done_b;
    end

    task automatic wait_a(input string tag);
        int n = 0;
        while (qda.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk({tag, "_timeout"}, qda.size(), 0);
        if (qda.size() != 0) begin qda.delete(); qsa.delete(); end
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        while (qdb.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk({tag, "_timeout"}, qdb.size(), 0);
        if (qdb.size() != 0) begin qdb.delete(); qsb.delete(); end
    endtask

    task automatic run_a(input string tag, input bit repulse);
        int n = 0;
        @(negedge clk);
        start_a = 1'b1;
        push_a(cyc + 1);
        @(negedge clk);
        start_a = 1'b0;
        chk({tag, "_accept_busy"}, busy_a, 1);
        chk({tag, "_accept_err"}, err_a, 0);
        chk({tag, "_accept_fv"}, fv_a, 0);
        chk({tag, "_accept_done"}, done_a, 0);
        if (repulse) begin
            while (stim_a != 3'd2 && n < 100) begin @(negedge clk); n++; end
            chk({tag, "_reach_stim2"}, stim_a, 2);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        wait_a(tag);
    endtask

    task automatic run_b(input string tag);
        @(negedge clk);
        start_b = 1'b1;
        push_b(cyc + 1);
        @(negedge clk);
        start_b = 1'b0;
        chk({tag, "_accept_err"}, err_b, 0);
        chk({tag, "_accept_done"}, done_b, 0);
        wait_b(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int e;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int r = 0; r < 8; r++) tab_a[r] = 1'(exp_row_a(r));
        for (int r = 0; r < 4; r++) tab_b[r] = 2'(r);
        repeat (3) @(negedge clk);
        chk("rst_stim", stim_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_step", step_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fail", {fv_a, fidx_a, fy_a}, 0);
        chk("rst_b_all", {busy_b, done_b, pass_b, err_b, fv_b, fidx_b, fy_b, stim_b}, 0);
`ifdef SWEEP_MISR_EN
        chk("rst_sig", sig_a, 0);
`endif
        reset = 1'b0;

        run_a("a_majority", 1'b0);
        for (int r = 0; r < 8; r++) tab_a[r] = 1'b0;
        run_a("a_stuck0", 1'b0);
        for (int r = 0; r < 8; r++) tab_a[r] = 1'(exp_row_a(r));
        run_a("a_repulse", 1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < 8; r++) tab_a[r] = 1'($urandom_range(0, 1));
            run_a("a_random", 1'b0);
        end

        // Start held high through DONE restarts immediately.
        for (int r = 0; r < 8; r++) tab_a[r] = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_a = 1'b1;
        e = cyc + 1;
        push_a(e);
        push_a(e + 17);
        n = 0;
        while (cyc < e + 17 && n < 100) begin @(negedge clk); n++; end
        start_a = 1'b0;
        wait_a("a_held");

        // Reset in the middle of a sweep discards everything.
        for (int r = 0; r < 8; r++) tab_a[r] = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        push_a(cyc + 1);
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (stim_a != 3'd5 && n < 100) begin @(negedge clk); n++; end
        chk("mid_reach_stim5", stim_a, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_stim", stim_a, 0);
        chk("mid_rst_err", err_a, 0);
        chk("mid_rst_fv", fv_a, 0);
`ifdef SWEEP_MISR_EN
        chk("mid_rst_sig", sig_a, 0);
`endif
        qsa.delete();
        qda.delete();
        seen = 0;
        repeat (40) begin @(negedge clk); if (done_a || busy_a) seen = 1; end
        chk("mid_rst_no_done", seen, 0);
        for (int r = 0; r < 8; r++) tab_a[r] = 1'(exp_row_a(r));
        run_a("a_after_reset", 1'b0);

        run_b("b_identity");
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 4; r++) tab_b[r] = 2'($urandom_range(0, 3));
            run_b("b_random");
        end
        for (int r = 0; r < 4; r++) tab_b[r] = 2'(r);
        run_b("b_identity_again");

        repeat (4) @(negedge clk);
        chk("end_qsa_empty", qsa.size(), 0);
        chk("end_qsb_empty", qsb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
